layer_sequencer: RTL

- Time-multiplexes a bank of N_MAC multiply-accumulate units over all N_NEURON neurons of one fully-connected layer.
- Per batch: programs each MAC's weight start offset, pulses run, waits for every enabled MAC's done, then drains the results serially into the layer output buffer.
- Sits between the network top-level control and the MAC bank; the downstream sigmoid stage reads the buffer after layer_done.

---
 rtl/layer_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: shares N_MAC MAC units across all neurons of one
// fully-connected layer, batch by batch, draining results to a buffer.
module layer_sequencer #(
  parameter int N_NEURON = 64,
  parameter int N_MAC    = 16,
  parameter int N_IN     = 12,
  parameter int W        = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 err,
  output logic                 mac_run,
  output logic [N_MAC-1:0]     mac_en,
  output logic [N_MAC*32-1:0]  mac_start,
  output logic [31:0]          mac_size,
  input  logic [N_MAC-1:0]     mac_done,
  input  logic [N_MAC*W-1:0]   mac_out,
  output logic                 res_we,
  output logic [7:0]           res_addr,
  output logic [W-1:0]         res_data
);
  localparam int NB = (N_NEURON + N_MAC - 1) / N_MAC;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int KW = (N_MAC > 1) ? $clog2(N_MAC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  localparam logic [KW-1:0] KLAST = KW'(N_MAC - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DRAIN, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     batch_q, batch_d;
  logic [KW-1:0]     k_q, k_d;
  logic [N_MAC-1:0]  mask_q, mask_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_q, err_d;

  logic [N_MAC-1:0]    en_c;
  logic [N_MAC*32-1:0] ofs_c;
  logic [31:0]         base_c;
  logic [31:0]         n_c;
  logic [N_MAC-1:0]    mask_nx;
  logic [W-1:0]        outs [N_MAC];
  logic                active;

  assign base_c  = 32'(batch_q) * 32'(N_MAC);
  assign n_c     = base_c + 32'(k_q);
  assign mask_nx = mask_q | (mac_done & en_c);
  assign active  = (state_q == ISSUE) ||
                   (state_q == WAIT)  ||
                   (state_q == DRAIN);

  for (genvar g = 0; g < N_MAC; g++) begin : g_mac
    assign outs[g] = mac_out[g*W +: W];
    assign en_c[g] = (base_c + 32'(g)) < 32'(N_NEURON);
    assign ofs_c[g*32 +: 32] = (base_c + 32'(g)) * 32'(N_IN);
  end

  // Batch setup is held steady for the MAC bank while the batch is live
  assign busy      = active;
  assign err       = err_q;
  assign mac_en    = active ? en_c : '0;
  assign mac_start = active ? ofs_c : '0;
  assign mac_size  = active ? 32'(N_IN) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      batch_q <= '0;
      k_q     <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      batch_q <= batch_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    k_d        = k_q;
    mask_d     = mask_q;
    timer_d    = timer_q;
    err_d      = err_q;
    mac_run    = 1'b0;
    layer_done = 1'b0;
    res_we     = 1'b0;
    res_addr   = '0;
    res_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          batch_d = '0;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        mac_run = 1'b1;
        mask_d  = '0;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        mask_d  = mask_nx;
        timer_d = timer_q + 1'b1;
        if (mask_nx == en_c) begin
          state_d = DRAIN;
          k_d     = '0;
        end else if (timer_q == TLAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DRAIN: begin
        res_we   = 1'b1;
        res_addr = n_c[7:0];
        res_data = outs[k_q];
        // enabled MACs are always the low-order ones of a batch
        if (k_q == KLAST || n_c == 32'(N_NEURON - 1)) begin
          if (batch_q == BLAST) begin
            state_d = DONE;
          end else begin
            batch_d = batch_q + 1'b1;
            state_d = ISSUE;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        layer_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
